// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the byte-enabled, word-aligned memory bus.
// Lanes are little-endian: lane i is byte address+i.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;
    localparam int WORD_W = LANE_W * LANES;
    localparam int CNT_W  = 4;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word array with per-lane write enables and a registered read port.
// The read register holds its value until the next read or clear.
module byte_lane_ram
    import mem_bus_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    AW          = 10,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [LANES-1:0]  we_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              rclr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LANES; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][i*LANE_W +: LANE_W] <= wdata_i[i*LANE_W +: LANE_W];
            end
        end
    end

    // Out-of-range reads return zero through the clear input.
    always_ff @(posedge clk_i) begin
        if (reset_i || rclr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/avalon_data_ram.sv
// Memory-side responder: one transfer at a time with programmable wait states,
// byte-lane writes, full-word reads and sticky protocol/range error flags.
module avalon_data_ram
    import mem_bus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
    parameter int          WAIT_CYCLES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address,
    input  logic              read,
    input  logic              write,
    input  logic [LANES-1:0]  byteenable,
    input  logic [WORD_W-1:0] writedata,
    output logic              waitrequest,
    output logic [WORD_W-1:0] readdata,
    output logic              protocol_error,
    output logic              range_error
);

    localparam int          AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] RANGE_BYTES = 32'(DEPTH_WORDS) << 2;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q;
    logic [LANES-1:0]   be_q;
    logic [WORD_W-1:0]  wdata_q;
    logic               rd_q, wr_q;
    logic               perr_q, rerr_q;

    logic               req;
    logic               access;
    logic [31:0]        offset;
    logic               in_range, proto_bad;
    logic [LANES-1:0]   ram_we;
    logic               ram_re, ram_rclr;

    assign req = read | write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The commit edge is the BUSY->DONE edge; a reset on that edge still wins.
    always_comb begin
        waitrequest = req && (state_q != DONE);
        access      = (state_q == BUSY) && req && (cnt_q == '0) && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else if (state_q == IDLE && req) begin
            addr_q  <= address;
            be_q    <= byteenable;
            wdata_q <= writedata;
            rd_q    <= read;
            wr_q    <= write;
        end
    end

    // Addresses below BASE_ADDR wrap to large offsets and fall out of range.
    assign offset    = addr_q - BASE_ADDR;
    assign in_range  = offset < RANGE_BYTES;
    assign proto_bad = !is_aligned(addr_q[1:0]) || (rd_q && wr_q);

    assign ram_we   = (access && wr_q && !proto_bad && in_range) ? be_q : '0;
    assign ram_re   = access && rd_q && !proto_bad && in_range;
    assign ram_rclr = access && rd_q && !proto_bad && !in_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            perr_q <= 1'b0;
            rerr_q <= 1'b0;
        end else if (access) begin
            if (proto_bad) perr_q <= 1'b1;
            if (!in_range) rerr_q <= 1'b1;
        end
    end

    byte_lane_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk_i   (clk),
        .reset_i (reset),
        .addr_i  (offset[AW+1:2]),
        .we_i    (ram_we),
        .wdata_i (wdata_q),
        .re_i    (ram_re),
        .rclr_i  (ram_rclr),
        .rdata_o (readdata)
    );

    assign protocol_error = perr_q;
    assign range_error    = rerr_q;

endmodule

// File: tb/tb_avalon_data_ram.sv
// Directed bench for avalon_data_ram: three instances (0, 3 and 4 wait states)
// share one set of master inputs; each scenario resets and checks one instance.
module tb_avalon_data_ram;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  byteenable = '0;
    logic [31:0] writedata = '0;

    logic [2:0]  wreq;
    logic [31:0] rdat [3];
    logic [2:0]  perr;
    logic [2:0]  rerr;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    avalon_data_ram #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata), .waitrequest(wreq[0]),
        .readdata(rdat[0]), .protocol_error(perr[0]), .range_error(rerr[0])
    );

    avalon_data_ram #(.WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata), .waitrequest(wreq[1]),
        .readdata(rdat[1]), .protocol_error(perr[1]), .range_error(rerr[1])
    );

    avalon_data_ram #(.WAIT_CYCLES(4)) u_dut2 (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata), .waitrequest(wreq[2]),
        .readdata(rdat[2]), .protocol_error(perr[2]), .range_error(rerr[2])
    );

    // Called and returns at posedge+1. stalls = cycles with waitrequest high.
    task automatic xfer(input int sel, input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d, input bit hold,
                        output int stalls, output logic [31:0] rd);
        address = a; byteenable = be; writedata = d; read = r; write = w;
        stalls = 0;
        rd = 'x;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (wreq[sel] === 1'b0) begin
                rd = rdat[sel];
                break;
            end
            stalls++;
        end
        @(posedge clk); #1;
        if (!hold) begin
            read = 1'b0; write = 1'b0;
        end
    endtask

    task automatic do_reset();
        read = 1'b0; write = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_total++; if (rdat[0] !== 32'h0) $display("FAIL reset_readdata got %h exp %h", rdat[0], 32'h0); else n_pass++;
        n_total++; if (perr[0] !== 1'b0) $display("FAIL reset_perr got %b exp 0", perr[0]); else n_pass++;
        n_total++; if (rerr[0] !== 1'b0) $display("FAIL reset_rerr got %b exp 0", rerr[0]); else n_pass++;
        n_total++; if (wreq[0] !== 1'b0) $display("FAIL reset_wreq got %b exp 0", wreq[0]); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int st; logic [31:0] rd;
        do_reset();
        xfer(0, 0, 1, 32'hBFC0_0004, 4'hF, 32'hDEAD_BEEF, 0, st, rd);
        n_total++; if (st !== 2) $display("FAIL basic_wr_stall got %0d exp 2", st); else n_pass++;
        xfer(0, 1, 0, 32'hBFC0_0004, 4'h0, 32'h0, 0, st, rd);
        n_total++; if (st !== 2) $display("FAIL basic_rd_stall got %0d exp 2", st); else n_pass++;
        n_total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL basic_rd_data got %h exp %h", rd, 32'hDEAD_BEEF); else n_pass++;
        xfer(0, 0, 1, 32'hBFC0_0008, 4'hF, 32'h0, 0, st, rd);
        @(negedge clk);
        n_total++; if (rdat[0] !== 32'hDEAD_BEEF) $display("FAIL basic_rd_hold got %h exp %h", rdat[0], 32'hDEAD_BEEF); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_byte_lane();
        int st; logic [31:0] rd;
        do_reset();
        xfer(0, 0, 1, 32'hBFC0_0004, 4'hF, 32'h1122_3344, 0, st, rd);
        xfer(0, 0, 1, 32'hBFC0_0004, 4'b0100, 32'hAABB_CCDD, 0, st, rd);
        xfer(0, 1, 0, 32'hBFC0_0004, 4'h0, 32'h0, 0, st, rd);
        n_total++; if (rd !== 32'h11BB_3344) $display("FAIL lane_be0100 got %h exp %h", rd, 32'h11BB_3344); else n_pass++;
        xfer(0, 0, 1, 32'hBFC0_0004, 4'b0000, 32'h9999_9999, 0, st, rd);
        n_total++; if (st !== 2) $display("FAIL lane_be0000_stall got %0d exp 2", st); else n_pass++;
        xfer(0, 1, 0, 32'hBFC0_0004, 4'h0, 32'h0, 0, st, rd);
        n_total++; if (rd !== 32'h11BB_3344) $display("FAIL lane_be0000 got %h exp %h", rd, 32'h11BB_3344); else n_pass++;
        xfer(0, 0, 1, 32'hBFC0_0004, 4'b1001, 32'h5566_7788, 0, st, rd);
        xfer(0, 1, 0, 32'hBFC0_0004, 4'h0, 32'h0, 0, st, rd);
        n_total++; if (rd !== 32'h55BB_3388) $display("FAIL lane_be1001 got %h exp %h", rd, 32'h55BB_3388); else n_pass++;
    endtask

    task automatic test_protocol();
        int st; logic [31:0] rd;
        do_reset();
        xfer(0, 0, 1, 32'hBFC0_0014, 4'hF, 32'hCAFE_F00D, 0, st, rd);
        xfer(0, 1, 0, 32'hBFC0_0014, 4'h0, 32'h0, 0, st, rd);
        xfer(0, 1, 0, 32'hBFC0_0002, 4'hF, 32'h0, 0, st, rd);
        n_total++; if (st !== 2) $display("FAIL misalign_stall got %0d exp 2", st); else n_pass++;
        n_total++; if (perr[0] !== 1'b1) $display("FAIL misalign_perr got %b exp 1", perr[0]); else n_pass++;
        n_total++; if (rerr[0] !== 1'b0) $display("FAIL misalign_rerr got %b exp 0", rerr[0]); else n_pass++;
        n_total++; if (rd !== 32'hCAFE_F00D) $display("FAIL misalign_rd got %h exp %h", rd, 32'hCAFE_F00D); else n_pass++;
        do_reset();
        n_total++; if (perr[0] !== 1'b0) $display("FAIL perr_cleared got %b exp 0", perr[0]); else n_pass++;
        xfer(0, 1, 1, 32'hBFC0_0014, 4'hF, 32'h0, 0, st, rd);
        n_total++; if (perr[0] !== 1'b1) $display("FAIL rdwr_perr got %b exp 1", perr[0]); else n_pass++;
        n_total++; if (rd !== 32'h0) $display("FAIL rdwr_rd got %h exp %h", rd, 32'h0); else n_pass++;
        xfer(0, 1, 0, 32'hBFC0_0014, 4'h0, 32'h0, 0, st, rd);
        n_total++; if (rd !== 32'hCAFE_F00D) $display("FAIL rdwr_mem got %h exp %h", rd, 32'hCAFE_F00D); else n_pass++;
        n_total++; if (perr[0] !== 1'b1) $display("FAIL perr_sticky got %b exp 1", perr[0]); else n_pass++;
    endtask

    task automatic test_range();
        int st; logic [31:0] rd;
        do_reset();
        xfer(0, 0, 1, 32'hBFC0_0000, 4'hF, 32'h0BAD_C0DE, 0, st, rd);
        xfer(0, 0, 1, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF, 0, st, rd);
        n_total++; if (rerr[0] !== 1'b1) $display("FAIL range_wr_rerr got %b exp 1", rerr[0]); else n_pass++;
        n_total++; if (perr[0] !== 1'b0) $display("FAIL range_wr_perr got %b exp 0", perr[0]); else n_pass++;
        xfer(0, 1, 0, 32'hBFC0_0000, 4'h0, 32'h0, 0, st, rd);
        n_total++; if (rd !== 32'h0BAD_C0DE) $display("FAIL range_wr_dropped got %h exp %h", rd, 32'h0BAD_C0DE); else n_pass++;
        xfer(0, 1, 0, 32'h0000_0000, 4'h0, 32'h0, 0, st, rd);
        n_total++; if (st !== 2) $display("FAIL range_rd_stall got %0d exp 2", st); else n_pass++;
        n_total++; if (rd !== 32'h0) $display("FAIL range_rd_zero got %h exp %h", rd, 32'h0); else n_pass++;
        do_reset();
        xfer(0, 0, 1, 32'hBFC0_0FFC, 4'hF, 32'h600D_F00D, 0, st, rd);
        xfer(0, 1, 0, 32'hBFC0_0FFC, 4'h0, 32'h0, 0, st, rd);
        n_total++; if (rd !== 32'h600D_F00D) $display("FAIL range_last_word got %h exp %h", rd, 32'h600D_F00D); else n_pass++;
        n_total++; if (rerr[0] !== 1'b0) $display("FAIL range_last_rerr got %b exp 0", rerr[0]); else n_pass++;
        xfer(0, 1, 0, 32'hBFC0_1000, 4'h0, 32'h0, 0, st, rd);
        n_total++; if (rd !== 32'h0) $display("FAIL range_past_end got %h exp %h", rd, 32'h0); else n_pass++;
        n_total++; if (rerr[0] !== 1'b1) $display("FAIL range_past_rerr got %b exp 1", rerr[0]); else n_pass++;
    endtask

    task automatic test_wait_states();
        int st; logic [31:0] rd;
        do_reset();
        xfer(1, 0, 1, 32'hBFC0_0008, 4'hF, 32'h1234_5678, 0, st, rd);
        n_total++; if (st !== 5) $display("FAIL ws_wr_stall got %0d exp 5", st); else n_pass++;
        xfer(1, 0, 1, 32'hBFC0_000C, 4'hF, 32'h8765_4321, 0, st, rd);
        xfer(1, 1, 0, 32'hBFC0_0008, 4'h0, 32'h0, 0, st, rd);
        n_total++; if (st !== 5) $display("FAIL ws_rd_stall got %0d exp 5", st); else n_pass++;
        n_total++; if (rd !== 32'h1234_5678) $display("FAIL ws_rd_data got %h exp %h", rd, 32'h1234_5678); else n_pass++;
        xfer(1, 1, 0, 32'hBFC0_000C, 4'h0, 32'h0, 1, st, rd);
        n_total++; if (st !== 5) $display("FAIL b2b_first_stall got %0d exp 5", st); else n_pass++;
        n_total++; if (rd !== 32'h8765_4321) $display("FAIL b2b_first_data got %h exp %h", rd, 32'h8765_4321); else n_pass++;
        xfer(1, 1, 0, 32'hBFC0_0008, 4'h0, 32'h0, 0, st, rd);
        n_total++; if (st !== 5) $display("FAIL b2b_second_stall got %0d exp 5", st); else n_pass++;
        n_total++; if (rd !== 32'h1234_5678) $display("FAIL b2b_second_data got %h exp %h", rd, 32'h1234_5678); else n_pass++;
    endtask

    task automatic test_abort();
        int st; logic [31:0] rd;
        do_reset();
        xfer(2, 0, 1, 32'hBFC0_000C, 4'hF, 32'h0102_0304, 0, st, rd);
        n_total++; if (st !== 6) $display("FAIL abort_wr_stall got %0d exp 6", st); else n_pass++;
        xfer(2, 0, 1, 32'hBFC0_0010, 4'hF, 32'h0A0B_0C0D, 0, st, rd);
        xfer(2, 1, 0, 32'hBFC0_000C, 4'h0, 32'h0, 0, st, rd);
        n_total++; if (rd !== 32'h0102_0304) $display("FAIL abort_pre_rd got %h exp %h", rd, 32'h0102_0304); else n_pass++;
        // Drop write two cycles in, while still counting down.
        address = 32'hBFC0_000C; byteenable = 4'hF; writedata = 32'hFFFF_FFFF; write = 1'b1;
        repeat (2) @(posedge clk);
        #1 write = 1'b0;
        // Drop a read of word 4 the same way; readdata must keep the old word.
        @(posedge clk); #1;
        address = 32'hBFC0_0010; read = 1'b1;
        repeat (2) @(posedge clk);
        #1 read = 1'b0;
        @(negedge clk);
        n_total++; if (rdat[2] !== 32'h0102_0304) $display("FAIL abort_rd_hold got %h exp %h", rdat[2], 32'h0102_0304); else n_pass++;
        @(posedge clk); #1;
        xfer(2, 1, 0, 32'hBFC0_000C, 4'h0, 32'h0, 0, st, rd);
        n_total++; if (st !== 6) $display("FAIL abort_idle_stall got %0d exp 6", st); else n_pass++;
        n_total++; if (rd !== 32'h0102_0304) $display("FAIL abort_no_commit got %h exp %h", rd, 32'h0102_0304); else n_pass++;
        // Reset in the middle of a write.
        address = 32'hBFC0_000C; byteenable = 4'hF; writedata = 32'hFFFF_FFFF; write = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1; write = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_total++; if (rdat[2] !== 32'h0) $display("FAIL rst_mid_readdata got %h exp %h", rdat[2], 32'h0); else n_pass++;
        n_total++; if (perr[2] !== 1'b0 || rerr[2] !== 1'b0) $display("FAIL rst_mid_flags got %b%b exp 00", perr[2], rerr[2]); else n_pass++;
        n_total++; if (wreq[2] !== 1'b0) $display("FAIL rst_mid_wreq got %b exp 0", wreq[2]); else n_pass++;
        @(posedge clk); #1;
        xfer(2, 1, 0, 32'hBFC0_000C, 4'h0, 32'h0, 0, st, rd);
        n_total++; if (st !== 6) $display("FAIL rst_mid_stall got %0d exp 6", st); else n_pass++;
        n_total++; if (rd !== 32'h0102_0304) $display("FAIL rst_mid_no_commit got %h exp %h", rd, 32'h0102_0304); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lane();
        test_protocol();
        test_range();
        test_wait_states();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
